answer_sequencer: RTL and testbench
===================================

ANSWER_SEQUENCER -- requirements
Module: answer_sequencer

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 18, meaning the number of responder bytes per frame (legal range 1..32).
REQ-002 SHALL have parameter LAT, default 1, meaning the responder read latency in clk cycles from an addr change to valid rd_data (legal range 1..7).
REQ-003 SHALL have port clk  input  1  meaning the single system clock, with all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning the asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  meaning a synchronous one-cycle frame request pulse.
REQ-006 SHALL have port addr  output  5  meaning the byte address driven to the responder.
REQ-007 SHALL have port rd_data  input  8  meaning the registered responder byte for addr.
REQ-008 SHALL have port tx_data  output  8  meaning the byte offered to the byte transmitter.
REQ-009 SHALL have port tx_valid  output  1  meaning tx_data is valid.
REQ-010 SHALL have port tx_ready  input  1  meaning the transmitter accepts; a handshake occurs on a cycle with tx_valid and tx_ready both high.
REQ-011 SHALL have port busy  output  1  meaning a frame is in progress (high in any state other than IDLE).
REQ-012 SHALL have port done  output  1  meaning a one-cycle pulse at the end of a frame.
REQ-013 SHALL have port overrun  output  1  meaning a sticky flag set when start arrives while busy.

Function
REQ-014 SHALL implement the states IDLE, WAIT, SEND, CSUM and DONE, all registered.
REQ-015 SHALL, in IDLE, hold addr=0, tx_valid=0 and busy=0; start moves the block to WAIT with addr=0, index=0, checksum=0 and the latency counter loaded with LAT+1, and clears overrun.
REQ-016 SHALL, in WAIT, decrement the latency counter each cycle; at zero it captures rd_data into tx_data, sets tx_valid=1 and moves to SEND, so capture happens on the (LAT+1)th edge after the edge that updated addr.
REQ-017 SHALL, in SEND, hold tx_data, tx_valid and addr stable until a handshake, with unbounded backpressure allowed.
REQ-018 SHALL, on a SEND handshake, add tx_data to the checksum as an 8-bit sum modulo 256 and drop tx_valid on the next cycle unless a new byte is being offered.
REQ-019 SHALL, on a SEND handshake with index < FRAME_LEN-1, increment addr and index and return to WAIT with the counter reloaded.
REQ-020 SHALL, on a SEND handshake with index == FRAME_LEN-1, go to CSUM when the checksum feature is compiled in, otherwise to DONE.
REQ-021 SHALL, in CSUM, present tx_data=checksum with tx_valid=1 until a handshake, then go to DONE.
REQ-022 SHALL, in DONE, assert done=1 for exactly one cycle, set addr to 0 and return to IDLE.
REQ-023 SHALL make addr visit 0..FRAME_LEN-1 exactly once each, in ascending order, per frame, and never exceed FRAME_LEN-1.
REQ-024 SHALL ignore start in any state other than IDLE (the frame in progress is unaffected) and set overrun=1.
REQ-025 SHALL ignore a start in DONE and set overrun; a start in the first IDLE cycle after DONE is accepted.
REQ-026 SHALL keep every byte sent under simultaneous tx_ready and state transitions; no byte is duplicated or dropped.

Reset
REQ-027 SHALL, while rst is low, asynchronously force state=IDLE and addr=0, tx_data=0, tx_valid=0, busy=0, done=0, overrun=0, index=0, checksum=0 and latency counter=0.
REQ-028 SHALL treat a reset mid-frame as abandoning the frame, with no done pulse and no checksum byte, and the next start after reset release begins again at addr=0.

Configuration
REQ-029 SHALL, when macro ANSWER_CHECKSUM_EN is defined, append the checksum byte (CSUM state), making a frame FRAME_LEN+1 bytes long.
REQ-030 SHALL, when ANSWER_CHECKSUM_EN is undefined, contain neither the CSUM state nor the checksum register, making a frame FRAME_LEN bytes long.

Structure
REQ-031 SHALL take the state enumeration, the default FRAME_LEN and LAT values, and the width constants (addr 5, data 8) from shared package answer_pkg.
REQ-032 SHALL be a single module with no sub-module; the latency counter stays inline.

Verification
REQ-033 SHALL cover: responder model with rd_data=10*addr for addr 1..15, addr0=0, addr16=0x05, addr17=0, tx_ready tied high, one start -> 18 bytes 0,10,...,150,5,0, then checksum 0xB5 (with ANSWER_CHECKSUM_EN), then a done pulse and busy low.
REQ-034 SHALL cover: tx_ready low for 3 cycles while byte 5 is offered -> tx_data=50 and addr=5 held all 3 cycles, with no duplicated byte.
REQ-035 SHALL cover: a second start at byte 9 -> overrun=1, the frame completes unchanged, and the next accepted start clears overrun.
REQ-036 SHALL cover: rst low during byte 7 -> all outputs 0 the same cycle with no done pulse, and a new start yields a full frame from addr 0.
REQ-037 SHALL cover: LAT=3 -> capture 4 edges after each addr update, with correct data.
REQ-038 SHALL cover: ANSWER_CHECKSUM_EN undefined -> exactly 18 handshakes, then done.

Source files
------------

// File: rtl/answer_pkg.sv
// -----------------------------------------------------------------------------
// answer_pkg
// Shared definitions for the answer sequencer: bus widths, parameter defaults
// and the FSM state encoding.
// Configuration macro: ANSWER_CHECKSUM_EN adds the CSUM state to the encoding.
// -----------------------------------------------------------------------------
package answer_pkg;

  localparam int ADDR_W        = 5;
  localparam int DATA_W        = 8;
  localparam int LAT_CNT_W     = 4;   // holds LAT+1 for LAT up to 7
  localparam int FRAME_LEN_DEF = 18;
  localparam int LAT_DEF       = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_SEND = 3'd2,
    ST_DONE = 3'd3
`ifdef ANSWER_CHECKSUM_EN
    ,
    ST_CSUM = 3'd4
`endif
  } state_e;

endpackage

// File: rtl/answer_sequencer.sv
// -----------------------------------------------------------------------------
// answer_sequencer
// Reads FRAME_LEN bytes from a registered responder (addr -> rd_data after LAT
// cycles) and streams them to a byte transmitter over a valid/ready handshake.
// With ANSWER_CHECKSUM_EN defined, a modulo-256 sum of the frame bytes is
// appended as one extra byte.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active low
//   start    in   one-cycle frame request (honoured only in IDLE)
//   addr     out  byte address to the responder
//   rd_data  in   responder byte for addr
//   tx_data  out  byte offered to the transmitter
//   tx_valid out  tx_data valid
//   tx_ready in   transmitter accepts
//   busy     out  frame in progress
//   done     out  one-cycle end-of-frame pulse
//   overrun  out  sticky: start seen while not IDLE, cleared by next accepted start
// -----------------------------------------------------------------------------
module answer_sequencer
  import answer_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int LAT       = LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0]    LAST_IDX = ADDR_W'(FRAME_LEN - 1);
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LAT + 1);

  state_e                r_state;
  logic [ADDR_W-1:0]     r_index;
  logic [LAT_CNT_W-1:0]  r_lat_cnt;
`ifdef ANSWER_CHECKSUM_EN
  logic [DATA_W-1:0]     r_csum;
`endif

  logic w_hs;
  assign w_hs = tx_valid & tx_ready;

  // NOTE: all state and outputs are registered here with non-blocking
  // assignments so every read in this block sees the pre-edge value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      addr      <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      r_index   <= '0;
      r_lat_cnt <= '0;
`ifdef ANSWER_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      // done is a pulse: only the transition into DONE raises it.
      done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          addr     <= '0;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          if (start) begin
            r_state   <= ST_WAIT;
            busy      <= 1'b1;
            r_index   <= '0;
            r_lat_cnt <= LAT_LOAD;
            overrun   <= 1'b0;
`ifdef ANSWER_CHECKSUM_EN
            r_csum    <= '0;
`endif
          end
        end

        // Counter is loaded with LAT+1 on the addr-update edge, so the capture
        // below lands on the (LAT+1)th edge after it.
        ST_WAIT: begin
          if (r_lat_cnt <= LAT_CNT_W'(1)) begin
            r_lat_cnt <= '0;
            tx_data   <= rd_data;
            tx_valid  <= 1'b1;
            r_state   <= ST_SEND;
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_CNT_W'(1);
          end
        end

        ST_SEND: begin
          if (w_hs) begin
`ifdef ANSWER_CHECKSUM_EN
            r_csum <= r_csum + tx_data;
`endif
            if (r_index < LAST_IDX) begin
              addr      <= addr + ADDR_W'(1);
              r_index   <= r_index + ADDR_W'(1);
              r_lat_cnt <= LAT_LOAD;
              tx_valid  <= 1'b0;
              r_state   <= ST_WAIT;
            end else begin
`ifdef ANSWER_CHECKSUM_EN
              // Fold the byte being accepted into the sum directly; tx_valid
              // stays high so the checksum is offered on the next cycle.
              tx_data <= r_csum + tx_data;
              r_state <= ST_CSUM;
`else
              tx_valid <= 1'b0;
              done     <= 1'b1;
              r_state  <= ST_DONE;
`endif
            end
          end
        end

`ifdef ANSWER_CHECKSUM_EN
        ST_CSUM: begin
          if (w_hs) begin
            tx_valid <= 1'b0;
            done     <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
`endif

        ST_DONE: begin
          addr    <= '0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase

      // A request outside IDLE never disturbs the running frame; it is only
      // flagged.
      if (start && (r_state != ST_IDLE)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_answer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_answer_sequencer
// Two instances: A (FRAME_LEN=18, LAT=1) for the directed and randomized
// frames, B (FRAME_LEN=5, LAT=3) for capture timing against a slower responder.
// Expected bytes are queued when a frame is requested and popped by monitors
// on every handshake.
// -----------------------------------------------------------------------------
module tb_answer_sequencer;
  import answer_pkg::*;

  localparam int FL_A  = 18;
  localparam int LAT_A = 1;
  localparam int FL_B  = 5;
  localparam int LAT_B = 3;
`ifdef ANSWER_CHECKSUM_EN
  localparam int CSUM_ON = 1;
`else
  localparam int CSUM_ON = 0;
`endif

  typedef struct {
    logic [7:0] data;
    logic [4:0] addr;
    bit         is_csum;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A signals
  logic       a_start, a_tx_ready, a_tx_valid, a_busy, a_done, a_overrun;
  logic [4:0] a_addr;
  logic [7:0] a_rd_data, a_tx_data;
  // Instance B signals
  logic       b_start, b_tx_ready, b_tx_valid, b_busy, b_done, b_overrun;
  logic [4:0] b_addr;
  logic [7:0] b_rd_data, b_tx_data;

  answer_sequencer #(.FRAME_LEN(FL_A), .LAT(LAT_A)) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .addr(a_addr), .rd_data(a_rd_data),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .busy(a_busy), .done(a_done), .overrun(a_overrun)
  );

  answer_sequencer #(.FRAME_LEN(FL_B), .LAT(LAT_B)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .addr(b_addr), .rd_data(b_rd_data),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .busy(b_busy), .done(b_done), .overrun(b_overrun)
  );

  // Responders: A answers one cycle after addr, B three cycles after addr.
  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];
  logic [4:0] b_pipe0, b_pipe1;

  always @(posedge clk) a_rd_data <= mem_a[a_addr];
  always @(posedge clk) begin
    b_pipe0   <= b_addr;
    b_pipe1   <= b_pipe0;
    b_rd_data <= mem_b[b_pipe1];
  end

  int errors = 0;
  int checks = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];
  int a_frames_exp = 0, a_dones = 0;
  int b_frames_exp = 0, b_dones = 0;
  bit rdy_random = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor A
  bit         a_prev_stall = 0, a_prev_done = 0;
  logic [7:0] a_stall_data;
  logic [4:0] a_stall_addr;
  int         a_hs_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      a_prev_stall = 0;
      a_prev_done  = 0;
      a_hs_cnt     = 0;
    end else begin
      if (a_prev_stall) begin
        check("a_stall_valid", a_tx_valid, 1);
        check("a_stall_data", a_tx_data, a_stall_data);
        check("a_stall_addr", a_addr, a_stall_addr);
      end
      if (a_tx_valid && a_tx_ready) begin
        check("a_byte_expected", exp_a.size() != 0, 1);
        if (exp_a.size() != 0) begin
          exp_t e;
          e = exp_a.pop_front();
          check(e.is_csum ? "a_csum_byte" : "a_data_byte", a_tx_data, e.data);
          if (!e.is_csum) check("a_byte_addr", a_addr, e.addr);
        end
        a_hs_cnt++;
      end
      a_prev_stall = a_tx_valid && !a_tx_ready;
      a_stall_data = a_tx_data;
      a_stall_addr = a_addr;
      if (a_done) begin
        check("a_done_width", a_prev_done, 0);
        check("a_done_hs_count", a_hs_cnt, FL_A + CSUM_ON);
        check("a_done_queue_empty", exp_a.size(), 0);
        a_dones++;
        a_hs_cnt = 0;
      end
      a_prev_done = a_done;
    end
  end

  // ---------------------------------------------------------------- monitor B
  bit         b_prev_valid = 0, b_prev_busy = 0;
  logic [4:0] b_prev_addr = '0;
  int         b_since = 0;

  always @(negedge clk) begin
    if (!rst) begin
      b_prev_valid = 0;
      b_prev_busy  = 0;
      b_prev_addr  = '0;
      b_since      = 0;
    end else begin
      if ((b_busy && !b_prev_busy) || (b_addr != b_prev_addr)) b_since = 0;
      else b_since++;
      if (b_tx_valid && !b_prev_valid) check("b_capture_edges", b_since, LAT_B + 1);
      if (b_tx_valid && b_tx_ready) begin
        check("b_byte_expected", exp_b.size() != 0, 1);
        if (exp_b.size() != 0) begin
          exp_t e;
          e = exp_b.pop_front();
          check("b_byte", b_tx_data, e.data);
          if (!e.is_csum) check("b_byte_addr", b_addr, e.addr);
        end
      end
      if (b_done) begin
        check("b_done_queue_empty", exp_b.size(), 0);
        b_dones++;
      end
      b_prev_valid = b_tx_valid;
      b_prev_busy  = b_busy;
      b_prev_addr  = b_addr;
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_random) a_tx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic start_frame_a();
    int sum = 0;
    for (int i = 0; i < FL_A; i++) begin
      exp_a.push_back('{data: mem_a[i], addr: 5'(i), is_csum: 1'b0});
      sum += int'(mem_a[i]);
    end
    if (CSUM_ON != 0) exp_a.push_back('{data: 8'(sum % 256), addr: 5'd0, is_csum: 1'b1});
    a_frames_exp++;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic start_frame_b();
    int sum = 0;
    for (int i = 0; i < FL_B; i++) begin
      exp_b.push_back('{data: mem_b[i], addr: 5'(i), is_csum: 1'b0});
      sum += int'(mem_b[i]);
    end
    if (CSUM_ON != 0) exp_b.push_back('{data: 8'(sum % 256), addr: 5'd0, is_csum: 1'b1});
    b_frames_exp++;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
  endtask

  // Returns at the cycle in which done is high.
  task automatic wait_done_a(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (a_done) begin seen = 1; break; end
      tick();
    end
    check("a_frame_done", seen, 1);
  endtask

  task automatic wait_done_b(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (b_done) begin seen = 1; break; end
      tick();
    end
    check("b_frame_done", seen, 1);
  endtask

  task automatic wait_addr_a(input logic [4:0] a, input bit need_valid, output bit ok);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (a_busy && a_addr == a && (!need_valid || a_tx_valid)) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic load_directed_mem();
    for (int i = 0; i < 32; i++) begin
      if (i >= 1 && i <= 15) mem_a[i] = 8'(10 * i);
      else if (i == 16)      mem_a[i] = 8'h05;
      else                   mem_a[i] = 8'h00;
    end
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    bit ok;
    rst = 1'b0;
    a_start = 1'b0; b_start = 1'b0;
    a_tx_ready = 1'b1; b_tx_ready = 1'b1;
    load_directed_mem();
    for (int i = 0; i < 32; i++) mem_b[i] = 8'(8'h30 + 7 * i);

    // Reset state
    repeat (3) tick();
    check("rst_addr", a_addr, 0);
    check("rst_tx_data", a_tx_data, 0);
    check("rst_tx_valid", a_tx_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_overrun", a_overrun, 0);
    rst = 1'b1;
    repeat (2) tick();

    // Basic frame with the fixed responder table, tx_ready always high
    start_frame_a();
    check("busy_after_start", a_busy, 1);
    wait_done_a(400);
    tick();
    check("busy_low_after_done", a_busy, 0);
    tick();

    // Backpressure on byte 5
    start_frame_a();
    wait_addr_a(5'd5, 1'b0, ok);
    check("reach_addr5", ok, 1);
    a_tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (a_tx_valid) break;
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      check("hold_byte5_data", a_tx_data, 50);
      check("hold_byte5_addr", a_addr, 5);
      if (k < 2) tick();
    end
    a_tx_ready = 1'b1;
    wait_done_a(400);
    tick();

    // Second start at byte 9: ignored, overrun flagged, frame unchanged
    start_frame_a();
    wait_addr_a(5'd9, 1'b1, ok);
    check("reach_addr9", ok, 1);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("overrun_set", a_overrun, 1);
    wait_done_a(400);
    // Start landing in DONE is ignored as well
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("done_start_overrun", a_overrun, 1);
    check("done_start_ignored", a_busy, 0);
    tick();
    check("idle_stays_idle", a_busy, 0);
    check("overrun_sticky", a_overrun, 1);
    start_frame_a();
    check("overrun_cleared", a_overrun, 0);
    wait_done_a(400);
    // Start in the first IDLE cycle after DONE is accepted
    tick();
    start_frame_a();
    check("start_after_done_busy", a_busy, 1);
    wait_done_a(400);
    tick();

    // Reset during byte 7 abandons the frame
    start_frame_a();
    wait_addr_a(5'd7, 1'b1, ok);
    check("reach_addr7", ok, 1);
    rst = 1'b0;
    #1;
    check("midrst_addr", a_addr, 0);
    check("midrst_tx_data", a_tx_data, 0);
    check("midrst_tx_valid", a_tx_valid, 0);
    check("midrst_busy", a_busy, 0);
    check("midrst_done", a_done, 0);
    check("midrst_overrun", a_overrun, 0);
    exp_a.delete();
    a_frames_exp--;
    repeat (2) tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_done_after_rst", a_done, 0);
    end
    start_frame_a();
    wait_done_a(400);
    tick();

    // Randomized contents and backpressure
    rdy_random = 1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 32; i++) mem_a[i] = 8'($urandom);
      start_frame_a();
      wait_done_a(3000);
      tick();
    end
    rdy_random = 0;
    a_tx_ready = 1'b1;

    // Slow responder instance
    for (int f = 0; f < 2; f++) begin
      start_frame_b();
      wait_done_b(400);
      tick();
    end

    repeat (4) tick();
    check("a_frames_completed", a_dones, a_frames_exp);
    check("a_queue_drained", exp_a.size(), 0);
    check("b_frames_completed", b_dones, b_frames_exp);
    check("b_queue_drained", exp_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
